// File: rtl/iob_caravel_cnt_ctrl.sv
// iob_caravel_cnt_ctrl: Wishbone-mapped CTRL/COUNT/CMP/STATUS registers for the Caravel user counter,
// with LA count override, GPIO output enable and compare-match interrupt.
module iob_caravel_cnt_ctrl #(
    parameter int          BITS      = 16,
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [BITS-1:0] la_data_in,
    input  logic [BITS-1:0] la_oenb,
    output logic [BITS-1:0] count_o,
    output logic            io_oeb_o,
    output logic            irq_o
);
    typedef enum logic {IDLE, ACK} state_t;

    state_t          state_q, state_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [BITS-1:0] count_q, count_d, cmp_q, cmp_d;
    logic            match_q, match_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     wmask, cnt_wr, cmp_wr;
    logic [1:0]      off;
    logic            req, wr, w1c, la_any, en, dir;
    logic            unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];
    assign off    = wbs_adr_i[3:2];
    assign req    = (state_q == IDLE) && wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == ADDR_BASE[31:4]);
    assign wr     = req && wbs_we_i;
    assign wmask  = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign cnt_wr = (wbs_dat_i & wmask) | (32'(count_q) & ~wmask);
    assign cmp_wr = (wbs_dat_i & wmask) | (32'(cmp_q) & ~wmask);
    assign w1c    = wr && (off == 2'd3) && wbs_sel_i[0] && wbs_dat_i[0];
    assign la_any = ~&la_oenb;
    assign en     = ctrl_q[0];
    assign dir    = ctrl_q[1];

    always_comb begin
        state_d = req ? ACK : IDLE;
        ctrl_d  = (wr && off == 2'd0 && wbs_sel_i[0]) ? wbs_dat_i[3:0] : ctrl_q;
        cmp_d   = (wr && off == 2'd2) ? BITS'(cmp_wr) : cmp_q;
        // LA override beats a same-edge bus write, which beats the free-running step
        count_d = la_any ? ((count_q & la_oenb) | (la_data_in & ~la_oenb))
                : (wr && off == 2'd1) ? BITS'(cnt_wr)
                : en ? (dir ? count_q - BITS'(1) : count_q + BITS'(1))
                : count_q;
        match_d = (en && count_q == cmp_q) || (match_q && !w1c);
        rdata_d = !(req && !wbs_we_i) ? 32'd0
                : (off == 2'd0) ? 32'(ctrl_d)
                : (off == 2'd1) ? 32'(count_d)
                : (off == 2'd2) ? 32'(cmp_d)
                : 32'(match_d);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            rdata_q <= rdata_d;
        end
    end

    assign wbs_ack_o = (state_q == ACK);
    assign wbs_dat_o = wbs_ack_o ? rdata_q : 32'd0;
    assign count_o   = count_q;
    assign io_oeb_o  = ~ctrl_q[3];
    assign irq_o     = match_q & ctrl_q[2];
endmodule

// File: tb/tb_iob_caravel_cnt_ctrl.sv
// tb_iob_caravel_cnt_ctrl: table vectors, directed corner sequences and random traffic
// checked against a register-level model of the counter controller.
module tb_iob_caravel_cnt_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = '0, adr = '0;
    logic        ack;
    logic [31:0] dout;
    logic [15:0] la_data = '0, la_oenb = 16'hFFFF;
    logic [15:0] cnt;
    logic        oeb, irq;

    int n_cmp = 0, n_bad = 0;
    int m_ctrl = 0, m_count = 0, m_cmp = 0, m_match = 0, m_rd = 0;
    bit m_ack = 0;

    typedef struct {
        logic [1:0]  off;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_oeb;
    } vec_t;
    vec_t vt[12];

    iob_caravel_cnt_ctrl #(.BITS(16), .ADDR_BASE(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dout),
        .la_data_in(la_data), .la_oenb(la_oenb),
        .count_o(cnt), .io_oeb_o(oeb), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register-level behaviour applied for one clock edge, using the inputs present before it
    task automatic model_edge();
        bit req, wr;
        int off, mask, en;
        req = cyc && stb && !m_ack && (adr[31:4] == BASE[31:4]);
        wr  = req && we;
        off = int'(adr[3:2]);
        mask = 0;
        for (int b = 0; b < 4; b++) if (sel[b]) mask |= 'hFF << (8 * b);
        en = m_ctrl & 1;
        if (wr && off == 3 && (dat & mask & 1) != 0) m_match = 0;
        if (en != 0 && m_count == m_cmp) m_match = 1;
        if (la_oenb != 16'hFFFF) begin
            for (int b = 0; b < 16; b++)
                if (!la_oenb[b]) m_count = la_data[b] ? (m_count | (1 << b)) : (m_count & ~(1 << b));
        end else if (wr && off == 1) m_count = ((dat & mask) | (m_count & ~mask)) & 'hFFFF;
        else if (en != 0) m_count = ((m_ctrl & 2) != 0) ? (m_count + 65535) % 65536 : (m_count + 1) % 65536;
        if (wr && off == 2) m_cmp = ((dat & mask) | (m_cmp & ~mask)) & 'hFFFF;
        if (wr && off == 0 && sel[0]) m_ctrl = dat & 15;
        m_rd = 0;
        if (req && !we) m_rd = (off == 0) ? m_ctrl : (off == 1) ? m_count : (off == 2) ? m_cmp : m_match;
        m_ack = req;
    endtask

    task automatic check_all();
        chk("ack", 32'(ack), 32'(m_ack));
        chk("dat_o", dout, m_ack ? m_rd : 0);
        chk("count_o", 32'(cnt), m_count);
        chk("io_oeb_o", 32'(oeb), ((m_ctrl & 8) != 0) ? 0 : 1);
        chk("irq_o", 32'(irq), (m_match != 0 && (m_ctrl & 4) != 0) ? 1 : 0);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic bus(input logic [1:0] o, input bit w, input logic [3:0] s, input logic [31:0] d,
                       output logic [31:0] rd);
        int n = 0;
        adr = BASE | (32'(o) << 2); we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
        do begin cycle(); n++; end while (ack !== 1'b1 && n < 4);
        chk("ack_latency", n, 1);
        rd = dout;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; la_oenb = 16'hFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_rd = 0; m_ack = 0;
    endtask

    initial begin
        logic [31:0] rd;
        vt[0]  = '{2'd3, 4'b0000, 32'h0000_0001, 32'h1,      1'b1};
        vt[1]  = '{2'd3, 4'b0001, 32'h0000_0001, 32'h0,      1'b1};
        vt[2]  = '{2'd2, 4'b0001, 32'hFFFF_FFFF, 32'h00FF,   1'b1};
        vt[3]  = '{2'd2, 4'b1111, 32'h1234_5678, 32'h5678,   1'b1};
        vt[4]  = '{2'd2, 4'b0010, 32'h0000_AB00, 32'hAB78,   1'b1};
        vt[5]  = '{2'd1, 4'b1111, 32'hFFFF_BEEF, 32'hBEEF,   1'b1};
        vt[6]  = '{2'd1, 4'b1100, 32'h0000_0000, 32'hBEEF,   1'b1};
        vt[7]  = '{2'd1, 4'b0001, 32'h0000_0042, 32'hBE42,   1'b1};
        vt[8]  = '{2'd0, 4'b1111, 32'hFFFF_FFF8, 32'h8,      1'b0};
        vt[9]  = '{2'd0, 4'b1110, 32'h0000_0007, 32'h8,      1'b0};
        vt[10] = '{2'd0, 4'b0001, 32'h0000_0004, 32'h4,      1'b1};
        vt[11] = '{2'd0, 4'b1111, 32'h0000_0000, 32'h0,      1'b1};

        do_reset();
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dat", dout, 0);
        chk("rst_count", 32'(cnt), 0);
        chk("rst_oeb", 32'(oeb), 1);
        chk("rst_irq", 32'(irq), 0);

        // enable + OE, then read COUNT: the read sees the value after its own edge
        bus(2'd0, 1, 4'hF, 32'h9, rd);
        chk("en_oeb", 32'(oeb), 0);
        chk("en_first_step", 32'(cnt), 1);
        bus(2'd1, 0, 4'hF, 0, rd);
        chk("count_read_post_edge", rd, 2);
        chk("count_after_read", 32'(cnt), 3);
        cycle();
        chk("count_step", 32'(cnt), 4);

        bus(2'd0, 1, 4'hF, 0, rd);
        bus(2'd1, 1, 4'hF, 32'hFFFF, rd);
        bus(2'd0, 1, 4'hF, 32'h1, rd);
        chk("wrap_up", 32'(cnt), 0);
        bus(2'd0, 1, 4'hF, 0, rd);
        bus(2'd1, 1, 4'hF, 0, rd);
        bus(2'd0, 1, 4'hF, 32'h3, rd);
        chk("wrap_down", 32'(cnt), 32'hFFFF);

        // compare match and interrupt
        bus(2'd0, 1, 4'hF, 0, rd);
        bus(2'd2, 1, 4'hF, 32'h10, rd);
        bus(2'd3, 1, 4'hF, 32'h1, rd);
        bus(2'd1, 1, 4'hF, 32'h0C, rd);
        bus(2'd0, 1, 4'hF, 32'h5, rd);
        chk("cmp_start", 32'(cnt), 32'h0D);
        for (int i = 0; i < 20 && cnt != 16'h0010; i++) cycle();
        chk("cmp_reach", 32'(cnt), 32'h10);
        chk("irq_before_match_edge", 32'(irq), 0);
        cycle();
        chk("irq_on_match", 32'(irq), 1);
        bus(2'd3, 1, 4'hF, 32'h1, rd);
        chk("irq_w1c", 32'(irq), 0);
        bus(2'd0, 1, 4'hF, 0, rd);
        bus(2'd1, 1, 4'hF, 32'h0F, rd);
        bus(2'd0, 1, 4'hF, 32'h5, rd);
        chk("set_wins_setup", 32'(cnt), 32'h10);
        bus(2'd3, 1, 4'hF, 32'h1, rd);
        chk("set_wins_over_w1c", 32'(irq), 1);

        // LA override beats same-edge bus COUNT write
        bus(2'd0, 1, 4'hF, 0, rd);
        bus(2'd1, 1, 4'hF, 32'h7700, rd);
        la_oenb = 16'hFF00; la_data = 16'h00AB;
        bus(2'd1, 1, 4'hF, 32'h1234, rd);
        la_oenb = 16'hFFFF;
        chk("la_override", 32'(cnt), 32'h77AB);

        // accesses outside the block are never acked and change nothing
        adr = 32'h3000_0014; we = 1'b1; sel = 4'hF; dat = 0; cyc = 1'b1; stb = 1'b1;
        repeat (3) begin cycle(); chk("miss_no_ack", 32'(ack), 0); end
        adr = 32'h2000_0004;
        repeat (2) begin cycle(); chk("miss_no_ack2", 32'(ack), 0); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        cycle();
        chk("miss_count_kept", 32'(cnt), 32'h77AB);

        foreach (vt[i]) begin
            bus(vt[i].off, 1, vt[i].sel, vt[i].wdata, rd);
            bus(vt[i].off, 0, 4'hF, 0, rd);
            chk($sformatf("vec%0d_read", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_oeb", i), 32'(oeb), 32'(vt[i].exp_oeb));
        end

        repeat (400) begin
            cyc = ($urandom_range(0, 3) != 0);
            stb = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            adr = ($urandom_range(0, 9) == 0) ? 32'h3000_0040 : (BASE | 32'($urandom_range(0, 15)));
            sel = 4'($urandom);
            dat = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 31)) : $urandom;
            la_oenb = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'hFFFF;
            la_data = 16'($urandom);
            cycle();
        end
        cyc = 1'b0; stb = 1'b0; la_oenb = 16'hFFFF;
        cycle();

        // asynchronous reset while counting and during an ack
        bus(2'd0, 1, 4'hF, 32'hD, rd);
        adr = BASE | 32'h4; we = 1'b1; sel = 4'hF; dat = 32'h5555; cyc = 1'b1; stb = 1'b1;
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ack", 32'(ack), 0);
        chk("async_rst_count", 32'(cnt), 0);
        chk("async_rst_oeb", 32'(oeb), 1);
        chk("async_rst_irq", 32'(irq), 0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_rd = 0; m_ack = 0;
        cycle();
        chk("post_rst_count", 32'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
